// File: rtl/array_write.sv
// array_write: array-side write engine.
// Accepts one row per sof/eof-delimited write frame on a valid/ready stream
// and drives row activation (cs_n), column write strobes and precharge.
// Array timing (tRCD_WR, tRAS, tWR, tRP) comes from run-time inputs that are
// captured when a frame starts and held until the frame completes.
module array_write #(
  parameter int ARRAY_COL_ADDR_WIDTH   = 6,
  parameter int ARRAY_ROW_ADDR_WIDTH   = 16,
  parameter int ARRAY_DATA_WIDTH       = 64,
  parameter int ARRAY_FRAME_DATA_WIDTH = 3 + ARRAY_COL_ADDR_WIDTH + ARRAY_ROW_ADDR_WIDTH + ARRAY_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_array_wframe_valid,
  input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] i_array_wframe_data,
  output logic                              o_array_wframe_ready,
  input  logic                              i_array_wr_start,
  output logic                              o_array_wr_done,
  input  logic [7:0]                        i_array_tRCD_WR,
  input  logic [7:0]                        i_array_tRAS,
  input  logic [7:0]                        i_array_tWR,
  input  logic [7:0]                        i_array_tRP,
  output logic                              o_array_cs_n,
  output logic [ARRAY_ROW_ADDR_WIDTH-1:0]   o_array_raddr,
  output logic                              o_array_caddr_vld_wr,
  output logic [ARRAY_COL_ADDR_WIDTH-1:0]   o_array_caddr_wr,
  output logic                              o_array_wdata_vld,
  output logic [ARRAY_DATA_WIDTH-1:0]       o_array_wdata
);

  // Frame beat field positions
  localparam int CADDR_LSB = 0;
  localparam int RADDR_LSB = ARRAY_COL_ADDR_WIDTH;
  localparam int DATA_LSB  = ARRAY_COL_ADDR_WIDTH + ARRAY_ROW_ADDR_WIDTH;
  localparam int RW_BIT    = DATA_LSB + ARRAY_DATA_WIDTH;
  localparam int SOF_BIT   = RW_BIT + 1;
  localparam int EOF_BIT   = RW_BIT + 2;

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RCD   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_TWR   = 3'd3;
  localparam logic [2:0] S_PRE   = 3'd4;

  // State and timing registers
  logic [2:0] r_state;
  logic [7:0] r_cnt;       // shared down-counter for RCD and PRE
  logic [7:0] r_ras_cnt;   // cycles with cs_n low, k+1 in cycle C+k, saturating
  logic [7:0] r_wr_cnt;    // cycles since the last write strobe, saturating
  logic [7:0] r_tras;
  logic [7:0] r_twr;       // already clamped to a minimum of 1
  logic [7:0] r_trp;

  // Registered array pins / handshake
  logic                            r_cs_n;
  logic [ARRAY_ROW_ADDR_WIDTH-1:0] r_raddr;
  logic                            r_ready;
  logic                            r_done;
  logic                            r_caddr_vld;
  logic [ARRAY_COL_ADDR_WIDTH-1:0] r_caddr;
  logic                            r_wdata_vld;
  logic [ARRAY_DATA_WIDTH-1:0]     r_wdata;

  // Next-state values
  logic [2:0]                      w_state_nx;
  logic [7:0]                      w_cnt_nx;
  logic [7:0]                      w_ras_cnt_nx;
  logic [7:0]                      w_wr_cnt_nx;
  logic [7:0]                      w_tras_nx;
  logic [7:0]                      w_twr_nx;
  logic [7:0]                      w_trp_nx;
  logic                            w_cs_n_nx;
  logic [ARRAY_ROW_ADDR_WIDTH-1:0] w_raddr_nx;
  logic                            w_ready_nx;
  logic                            w_done_nx;
  logic                            w_strobe_nx;
  logic [ARRAY_COL_ADDR_WIDTH-1:0] w_caddr_nx;
  logic [ARRAY_DATA_WIDTH-1:0]     w_wdata_nx;

  // Beat fields and derived conditions
  logic                            w_sof;
  logic                            w_eof;
  logic                            w_rw;
  logic [ARRAY_COL_ADDR_WIDTH-1:0] w_beat_caddr;
  logic [ARRAY_ROW_ADDR_WIDTH-1:0] w_beat_raddr;
  logic [ARRAY_DATA_WIDTH-1:0]     w_beat_data;
  logic                            w_start;
  logic                            w_accept;
  logic [7:0]                      w_trcd_eff;
  logic [7:0]                      w_twr_eff;
  logic                            w_ras_met;
  logic                            w_wr_met;

  assign w_sof        = i_array_wframe_data[SOF_BIT];
  assign w_eof        = i_array_wframe_data[EOF_BIT];
  assign w_rw         = i_array_wframe_data[RW_BIT];
  assign w_beat_caddr = i_array_wframe_data[CADDR_LSB +: ARRAY_COL_ADDR_WIDTH];
  assign w_beat_raddr = i_array_wframe_data[RADDR_LSB +: ARRAY_ROW_ADDR_WIDTH];
  assign w_beat_data  = i_array_wframe_data[DATA_LSB +: ARRAY_DATA_WIDTH];

  // A frame starts only when start, valid, sof and write flag coincide
  assign w_start    = i_array_wr_start & i_array_wframe_valid & w_sof & w_rw;
  // Beats are only accepted while ready is presented (WRITE state)
  assign w_accept   = i_array_wframe_valid & r_ready;
  // Zero activate-to-write or write-recovery still needs one cycle
  assign w_trcd_eff = (i_array_tRCD_WR == 8'd0) ? 8'd1 : i_array_tRCD_WR;
  assign w_twr_eff  = (i_array_tWR == 8'd0) ? 8'd1 : i_array_tWR;
  // A zero tRAS is satisfied immediately by the >= compare
  assign w_ras_met  = (r_ras_cnt >= r_tras);
  assign w_wr_met   = (r_wr_cnt >= r_twr);

  // Next-state and next-output computation for the write FSM
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_wr_cnt_nx  = r_wr_cnt;
    w_tras_nx    = r_tras;
    w_twr_nx     = r_twr;
    w_trp_nx     = r_trp;
    w_cs_n_nx    = r_cs_n;
    w_raddr_nx   = r_raddr;
    w_ready_nx   = r_ready;
    w_done_nx    = 1'b0;
    w_strobe_nx  = 1'b0;
    w_caddr_nx   = r_caddr;
    w_wdata_nx   = r_wdata;

    // tRAS keeps counting through bubbles for as long as the row is open
    if (!r_cs_n && (r_ras_cnt != 8'hFF)) begin
      w_ras_cnt_nx = r_ras_cnt + 8'd1;
    end else begin
      w_ras_cnt_nx = r_ras_cnt;
    end

    case (r_state)
      S_IDLE: begin
        w_ready_nx = 1'b0;
        w_cs_n_nx  = 1'b1;
        if (w_start) begin
          // The sof beat stays on the bus; it is consumed in WRITE
          w_raddr_nx   = w_beat_raddr;
          w_tras_nx    = i_array_tRAS;
          w_twr_nx     = w_twr_eff;
          w_trp_nx     = i_array_tRP;
          w_cs_n_nx    = 1'b0;
          w_ras_cnt_nx = 8'd1;
          // ready must be visible in the (tRCD-1)th cycle after activation
          if (w_trcd_eff == 8'd1) begin
            w_state_nx = S_WRITE;
            w_ready_nx = 1'b1;
          end else begin
            w_state_nx = S_RCD;
            w_cnt_nx   = w_trcd_eff - 8'd2;
          end
        end else begin
          w_state_nx = S_IDLE;
        end
      end

      S_RCD: begin
        if (r_cnt == 8'd0) begin
          w_state_nx = S_WRITE;
          w_ready_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end

      S_WRITE: begin
        if (w_accept) begin
          w_strobe_nx = 1'b1;
          w_caddr_nx  = w_beat_caddr;
          w_wdata_nx  = w_beat_data;
          if (w_eof) begin
            w_ready_nx  = 1'b0;
            w_state_nx  = S_TWR;
            w_wr_cnt_nx = 8'd0;
          end else begin
            w_state_nx = S_WRITE;
          end
        end else begin
          // Bubble: hold ready, no strobe
          w_state_nx = S_WRITE;
        end
      end

      S_TWR: begin
        if (w_wr_met && w_ras_met) begin
          w_state_nx = S_PRE;
          w_cs_n_nx  = 1'b1;
          w_cnt_nx   = r_trp;
          // With tRP of zero, done coincides with the first precharge cycle
          w_done_nx  = (r_trp == 8'd0);
        end else if (r_wr_cnt != 8'hFF) begin
          w_wr_cnt_nx = r_wr_cnt + 8'd1;
        end else begin
          w_wr_cnt_nx = r_wr_cnt;
        end
      end

      S_PRE: begin
        if (r_cnt == 8'd0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx  = r_cnt - 8'd1;
          w_done_nx = (r_cnt == 8'd1);
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_cs_n_nx  = 1'b1;
        w_ready_nx = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_ras_cnt   <= 8'd0;
      r_wr_cnt    <= 8'd0;
      r_tras      <= 8'd0;
      r_twr       <= 8'd1;
      r_trp       <= 8'd0;
      r_cs_n      <= 1'b1;
      r_raddr     <= '0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_caddr_vld <= 1'b0;
      r_caddr     <= '0;
      r_wdata_vld <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_ras_cnt   <= w_ras_cnt_nx;
      r_wr_cnt    <= w_wr_cnt_nx;
      r_tras      <= w_tras_nx;
      r_twr       <= w_twr_nx;
      r_trp       <= w_trp_nx;
      r_cs_n      <= w_cs_n_nx;
      r_raddr     <= w_raddr_nx;
      r_ready     <= w_ready_nx;
      r_done      <= w_done_nx;
      r_caddr_vld <= w_strobe_nx;
      r_caddr     <= w_caddr_nx;
      r_wdata_vld <= w_strobe_nx;
      r_wdata     <= w_wdata_nx;
    end
  end

  assign o_array_wframe_ready = r_ready;
  assign o_array_wr_done      = r_done;
  assign o_array_cs_n         = r_cs_n;
  assign o_array_raddr        = r_raddr;
  assign o_array_caddr_vld_wr = r_caddr_vld;
  assign o_array_caddr_wr     = r_caddr;
  assign o_array_wdata_vld    = r_wdata_vld;
  assign o_array_wdata        = r_wdata;

endmodule

// File: tb/tb_array_write.sv
// Testbench for array_write: directed scenarios plus randomized frames,
// checked cycle by cycle against a timing-rule reference model.
module tb_array_write;
  localparam int FW = 89;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          start;
  logic [FW-1:0] fdata;
  logic [7:0]    t_rcd, t_ras, t_wr, t_rp;
  logic          ready, done, cs_n, cvld, dvld;
  logic [15:0]   raddr;
  logic [5:0]    caddr;
  logic [63:0]   wdata;

  array_write dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_array_wframe_valid (valid),
    .i_array_wframe_data  (fdata),
    .o_array_wframe_ready (ready),
    .i_array_wr_start     (start),
    .o_array_wr_done      (done),
    .i_array_tRCD_WR      (t_rcd),
    .i_array_tRAS         (t_ras),
    .i_array_tWR          (t_wr),
    .i_array_tRP          (t_rp),
    .o_array_cs_n         (cs_n),
    .o_array_raddr        (raddr),
    .o_array_caddr_vld_wr (cvld),
    .o_array_caddr_wr     (caddr),
    .o_array_wdata_vld    (dvld),
    .o_array_wdata        (wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Frame storage (two slots so a following frame can be queued)
  logic [63:0] f_data [2][16];
  logic [5:0]  f_caddr[2][16];
  logic [17:0] f_junk [2][16];
  int          f_gap  [2][16];
  int          f_n    [2];
  logic [15:0] f_raddr[2];

  // Inputs presented once the frame's last beat has been taken
  logic          post_valid;
  logic          post_start;
  logic [FW-1:0] post_data;

  // Observations of the last frame, cycle numbers relative to C
  int obs_fall, obs_ready, obs_first, obs_last, obs_rise, obs_done, obs_done_cnt, obs_stb_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ctl();
    return {cs_n, ready, cvld, dvld, done};
  endfunction

  function automatic logic [FW-1:0] beat_of(input int s, input int k);
    logic [FW-1:0] b;
    if (k == 0)
      b = {(f_n[s] == 1), 1'b1, 1'b1, f_data[s][k], f_raddr[s], f_caddr[s][k]};
    else
      b = {(k == f_n[s] - 1), f_junk[s][k][17], f_junk[s][k][16], f_data[s][k],
           f_junk[s][k][15:0], f_caddr[s][k]};
    return b;
  endfunction

  task automatic fill_nominal(input int s);
    f_n[s] = 8;
    f_raddr[s] = 16'd1;
    for (int k = 0; k < 16; k++) begin
      f_caddr[s][k] = 6'(k + 1);               // data[21:0] = 65+k
      f_data[s][k]  = 64'hA5A5_0000_0000_0000 + 64'(k * 32'h0101_1111);
      f_junk[s][k]  = {1'b0, 1'b1, 16'd1};
      f_gap[s][k]   = 0;
    end
  endtask

  task automatic fill_rand(input int s);
    f_n[s] = int'($urandom_range(1, 8));
    f_raddr[s] = 16'($urandom);
    for (int k = 0; k < 16; k++) begin
      f_caddr[s][k] = 6'($urandom);
      f_data[s][k]  = {$urandom, $urandom};
      f_junk[s][k]  = 18'($urandom);
      f_gap[s][k]   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
    end
  endtask

  task automatic idle_cycles(input int k, input logic st, input logic v, input logic [FW-1:0] d);
    for (int i = 0; i < k; i++) begin
      start = st; valid = v; fdata = d;
      @(negedge clk);
      check("idle_ctl", ctl(), 5'b10000);
      @(posedge clk); #1;
    end
    start = 1'b0; valid = 1'b0;
  endtask

  // Runs one frame from its start cycle (t=0 = S, t=1 = C). Expected pins are
  // derived from the timing rules: cs_n low over [C, P), ready from C+tRCD-1
  // until the last beat, strobe one cycle after each accept, done at P+tRP.
  task automatic run_frame(input int s, input int trcd, input int tras, input int twr,
                           input int trp, input int abort_at);
    int t, acc, idx, gap_left, p, trcd_eff, twr_eff, n;
    bit p_known, acc_prev, vld, acc_now, exp_cs_n, exp_rdy, exp_done, fin, seen_low;
    logic [5:0]  prev_ca;
    logic [63:0] prev_d;
    n = f_n[s]; acc = 0; idx = 0; gap_left = 0; p = 0; t = 0;
    p_known = 1'b0; acc_prev = 1'b0; fin = 1'b0; seen_low = 1'b0;
    prev_ca = '0; prev_d = '0;
    trcd_eff = (trcd == 0) ? 1 : trcd;
    twr_eff  = (twr == 0) ? 1 : twr;
    obs_fall = -1; obs_ready = -1; obs_first = -1; obs_last = -1;
    obs_rise = -1; obs_done = -1; obs_done_cnt = 0; obs_stb_cnt = 0;
    while (!fin && t < 1000) begin
      if (t == 0) begin
        t_rcd = 8'(trcd); t_ras = 8'(tras); t_wr = 8'(twr); t_rp = 8'(trp);
        start = 1'b1;
      end else begin
        // timing must have been captured at start; scramble it afterwards
        t_rcd = 8'($urandom); t_ras = 8'($urandom); t_wr = 8'($urandom); t_rp = 8'($urandom);
        start = (idx < n) ? 1'($urandom_range(0, 1)) : post_start;
      end
      if (idx < n) begin
        vld = (gap_left == 0); valid = vld; fdata = beat_of(s, idx);
      end else begin
        vld = 1'b0; valid = post_valid; fdata = post_data;
      end
      if (abort_at >= 0 && acc == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ctl", ctl(), 5'b10000);
        check("rst_async_raddr", raddr, 16'd0);
        check("rst_async_caddr", caddr, 6'd0);
        check("rst_async_wdata", wdata, 64'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("rst_hold_ctl", ctl(), 5'b10000);
        end
        rst_n = 1'b1;
        valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      exp_cs_n = !((t >= 1) && (!p_known || t < p));
      exp_rdy  = (t >= trcd_eff) && (acc < n);
      exp_done = p_known && (t == p + trp);
      check("frame_ctl", ctl(), {exp_cs_n, exp_rdy, acc_prev, acc_prev, exp_done});
      if (t >= 1) check("frame_raddr", raddr, f_raddr[s]);
      if (acc_prev) begin
        check("frame_caddr", caddr, prev_ca);
        check("frame_wdata", wdata, prev_d);
      end
      if (!cs_n && !seen_low) begin seen_low = 1'b1; obs_fall = cyc; end
      if (cs_n && seen_low && obs_rise < 0) obs_rise = t - 1;
      if (ready && obs_ready < 0) obs_ready = t - 1;
      if (cvld) begin
        if (obs_first < 0) obs_first = t - 1;
        obs_last = t - 1;
        obs_stb_cnt++;
      end
      if (done) begin obs_done = t - 1; obs_done_cnt++; end
      acc_now = vld && exp_rdy;
      if (idx < n && !vld) gap_left--;
      acc_prev = acc_now;
      if (acc_now) begin
        prev_ca  = f_caddr[s][idx];
        prev_d   = f_data[s][idx];
        gap_left = f_gap[s][idx];
        if (idx == n - 1) begin
          p_known = 1'b1;
          // last strobe at L=t+1: P = max(L+tWR+1, C+tRAS)
          p = (t + twr_eff + 2 > tras + 1) ? t + twr_eff + 2 : tras + 1;
        end
        idx++; acc++;
      end
      if (p_known && t == p + trp) fin = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    if (!fin) check("frame_timeout", t, 0);
  endtask

  initial begin
    logic [FW-1:0] b;
    bit chain;
    int cur;
    int fall_a;
    rst_n = 1'b0; valid = 1'b0; start = 1'b0; fdata = '0;
    t_rcd = 8'd0; t_ras = 8'd0; t_wr = 8'd0; t_rp = 8'd0;
    post_valid = 1'b0; post_start = 1'b0; post_data = '0;

    // Reset values
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_ctl", ctl(), 5'b10000);
      check("reset_raddr", raddr, 16'd0);
      check("reset_caddr", caddr, 6'd0);
      check("reset_wdata", wdata, 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal 8-beat frame
    fill_nominal(0);
    run_frame(0, 7, 16, 3, 6, -1);
    check("nom_ready", obs_ready, 6);
    check("nom_first_strobe", obs_first, 7);
    check("nom_last_strobe", obs_last, 14);
    check("nom_csn_rise", obs_rise, 18);
    check("nom_done", obs_done, 24);
    check("nom_done_cnt", obs_done_cnt, 1);
    idle_cycles(2, 1'b0, 1'b0, '0);

    // tRAS-dominated single-beat frame
    fill_rand(1);
    f_n[1] = 1;
    run_frame(1, 2, 32, 1, 3, -1);
    check("ras_strobe", obs_first, 2);
    check("ras_csn_rise", obs_rise, 32);
    check("ras_done", obs_done, 35);
    idle_cycles(2, 1'b0, 1'b0, '0);

    // Bubbles: three idle cycles after the third beat of six
    fill_rand(0);
    f_n[0] = 6;
    for (int k = 0; k < 16; k++) f_gap[0][k] = 0;
    f_gap[0][2] = 3;
    run_frame(0, 3, 0, 2, 2, -1);
    check("bub_strobe_cnt", obs_stb_cnt, 6);
    check("bub_last_strobe", obs_last, 11);
    check("bub_csn_rise", obs_rise, 14);
    idle_cycles(2, 1'b0, 1'b0, '0);

    // Rejected starts
    b = {1'b0, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 16'h00AA, 6'd3};
    idle_cycles(4, 1'b1, 1'b1, b);
    b = {1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 16'h00AA, 6'd3};
    idle_cycles(4, 1'b1, 1'b1, b);
    b = {1'b0, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 16'h00AA, 6'd3};
    idle_cycles(4, 1'b1, 1'b0, b);

    // Reset mid-WRITE after two beats, then a clean nominal frame
    fill_nominal(0);
    run_frame(0, 7, 16, 3, 6, 2);
    check("rst_no_done", obs_done_cnt, 0);
    idle_cycles(3, 1'b0, 1'b0, '0);
    run_frame(0, 7, 16, 3, 6, -1);
    check("nom2_ready", obs_ready, 6);
    check("nom2_first_strobe", obs_first, 7);
    check("nom2_csn_rise", obs_rise, 18);
    check("nom2_done", obs_done, 24);
    check("nom2_done_cnt", obs_done_cnt, 1);
    idle_cycles(2, 1'b0, 1'b0, '0);

    // Back-to-back frames with start held and the second frame queued
    fill_rand(0); f_n[0] = 3;
    for (int k = 0; k < 16; k++) f_gap[0][k] = 0;
    fill_rand(1);
    post_valid = 1'b1; post_start = 1'b1; post_data = beat_of(1, 0);
    run_frame(0, 3, 0, 2, 4, -1);
    fall_a = obs_fall;
    check("b2b_done_cnt_a", obs_done_cnt, 1);
    post_valid = 1'b0; post_start = 1'b0; post_data = '0;
    run_frame(1, 2, 5, 1, 1, -1);
    check("b2b_fall_gap", obs_fall - fall_a, 14);
    check("b2b_done_cnt_b", obs_done_cnt, 1);
    idle_cycles(2, 1'b0, 1'b0, '0);

    // Randomized frames, sometimes chained
    fill_rand(0);
    for (int r = 0; r < 24; r++) begin
      cur = r % 2;
      fill_rand(1 - cur);
      chain = (r < 23) && ($urandom_range(0, 1) == 1);
      if (chain) begin
        post_valid = 1'b1; post_start = 1'b1; post_data = beat_of(1 - cur, 0);
      end else begin
        post_valid = 1'b0; post_start = 1'($urandom_range(0, 1)); post_data = '0;
      end
      run_frame(cur, int'($urandom_range(0, 6)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), -1);
      check("rnd_done_cnt", obs_done_cnt, 1);
      if (!chain) idle_cycles(2, 1'b0, 1'b0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
